// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronizes rst_req_n, waits for a stable hold, then releases domains in order.
// Optional request glitch filter in RELEASE/DONE is enabled by defining RST_SEQ_FILTER_EN.
module rst_seq_ctrl #(
    parameter int SYNC_STAGES   = 2,
    parameter int NUM_DOMAINS   = 3,
    parameter int HOLD_CYCLES   = 16,
    parameter int STAGE_GAP     = 4,
    parameter int FILTER_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rst_req_n,
    output logic [NUM_DOMAINS-1:0] rst_out_n,
    output logic                   seq_done
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam int GAP_W  = $clog2(STAGE_GAP) + 1;
    localparam int IDX_W  = $clog2(NUM_DOMAINS) + 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DOMAINS - 1);

    if (SYNC_STAGES < 2 || NUM_DOMAINS < 1 || HOLD_CYCLES < 1 || STAGE_GAP < 1 || FILTER_CYCLES < 1) begin : g_badParams
        $error("rst_seq_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_DONE
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state, w_stateNext;
    logic [HOLD_W-1:0]      r_holdCnt, w_holdNext;
    logic [GAP_W-1:0]       r_gapCnt, w_gapNext;
    logic [IDX_W-1:0]       r_idx, w_idxNext;
    logic [NUM_DOMAINS-1:0] r_out, w_outNext;
    logic                   r_done, w_doneNext;
    logic                   w_reqS;
    logic                   w_reqQual;

    assign w_reqS    = r_sync[SYNC_STAGES-1];
    assign rst_out_n = r_out;
    assign seq_done  = r_done;

`ifdef RST_SEQ_FILTER_EN
    localparam int FILT_W = $clog2(FILTER_CYCLES) + 1;
    localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FILTER_CYCLES - 1);

    logic [FILT_W-1:0] r_filt, w_filtNext;

    // A request only counts once req_s has stayed low for FILTER_CYCLES cycles outside ASSERT.
    always_comb begin
        w_filtNext = '0;
        w_reqQual  = !w_reqS && (r_filt == FILT_MAX);
        if (r_state != ST_ASSERT && !w_reqS && r_filt != FILT_MAX)
            w_filtNext = r_filt + FILT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_filt <= '0;
        else        r_filt <= w_filtNext;
    end
`else
    assign w_reqQual = !w_reqS;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync    <= '0;
            r_state   <= ST_ASSERT;
            r_holdCnt <= '0;
            r_gapCnt  <= '0;
            r_idx     <= '0;
            r_out     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], rst_req_n};
            r_state   <= w_stateNext;
            r_holdCnt <= w_holdNext;
            r_gapCnt  <= w_gapNext;
            r_idx     <= w_idxNext;
            r_out     <= w_outNext;
            r_done    <= w_doneNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_holdNext  = r_holdCnt;
        w_gapNext   = r_gapCnt;
        w_idxNext   = r_idx;
        w_outNext   = r_out;
        w_doneNext  = r_done;
        case (r_state)
            ST_ASSERT: begin
                w_outNext  = '0;
                w_doneNext = 1'b0;
                w_gapNext  = '0;
                w_idxNext  = '0;
                if (!w_reqS) begin
                    w_holdNext = '0;
                end else if (r_holdCnt == HOLD_MAX) begin
                    w_holdNext   = '0;
                    w_outNext[0] = 1'b1;
                    w_idxNext    = IDX_W'(1);
                    if (NUM_DOMAINS == 1) begin
                        w_stateNext = ST_DONE;
                        w_doneNext  = 1'b1;
                    end else begin
                        w_stateNext = ST_RELEASE;
                    end
                end else begin
                    w_holdNext = r_holdCnt + HOLD_W'(1);
                end
            end
            ST_RELEASE: begin
                // A qualified request takes priority over a release due on the same edge.
                if (w_reqQual) begin
                    w_stateNext = ST_ASSERT;
                    w_outNext   = '0;
                    w_doneNext  = 1'b0;
                    w_holdNext  = '0;
                    w_gapNext   = '0;
                    w_idxNext   = '0;
                end else if (r_gapCnt == GAP_MAX) begin
                    w_gapNext = '0;
                    for (int k = 0; k < NUM_DOMAINS; k++)
                        if (r_idx == IDX_W'(k)) w_outNext[k] = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_stateNext = ST_DONE;
                        w_doneNext  = 1'b1;
                    end else begin
                        w_idxNext = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_gapNext = r_gapCnt + GAP_W'(1);
                end
            end
            default: begin
                if (w_reqQual || r_state != ST_DONE) begin
                    w_stateNext = ST_ASSERT;
                    w_outNext   = '0;
                    w_doneNext  = 1'b0;
                    w_holdNext  = '0;
                    w_gapNext   = '0;
                    w_idxNext   = '0;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Testbench for rst_seq_ctrl: table-driven sequence on a 3-domain instance plus a 1-domain corner case.
// Expectations follow the RST_SEQ_FILTER_EN setting of the build.
module tb_rst_seq_ctrl;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       reqN = 1'b1;
   logic [2:0] rstOutN;
   logic       seqDone;

   logic       rstN2 = 1'b0;
   logic       reqN2 = 1'b1;
   logic [0:0] rstOutN2;
   logic       seqDone2;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       rstN;
      logic       reqN;
      int         edges;
      logic [2:0] expOut;
      logic       expDone;
      string      name;
   } vec_t;

   vec_t vecs[$];

   rst_seq_ctrl #(
      .SYNC_STAGES(2), .NUM_DOMAINS(3), .HOLD_CYCLES(16), .STAGE_GAP(4), .FILTER_CYCLES(8)
   ) dut (
      .clk(clk), .rst_n(rstN), .rst_req_n(reqN), .rst_out_n(rstOutN), .seq_done(seqDone)
   );

   rst_seq_ctrl #(
      .SYNC_STAGES(2), .NUM_DOMAINS(1), .HOLD_CYCLES(1), .STAGE_GAP(4), .FILTER_CYCLES(8)
   ) dutOne (
      .clk(clk), .rst_n(rstN2), .rst_req_n(reqN2), .rst_out_n(rstOutN2), .seq_done(seqDone2)
   );

   // Free-running 10 ns clock shared by both instances.
   always #5 clk = ~clk;

   task automatic addVec(input logic r, input logic q, input int n, input logic [2:0] o,
                         input logic d, input string nm);
      vec_t v;
      v.rstN = r; v.reqN = q; v.edges = n; v.expOut = o; v.expDone = d; v.name = nm;
      vecs.push_back(v);
   endtask

   task automatic checkOutput(input string nm, input logic [2:0] actOut, input logic actDone,
                              input logic [2:0] expOut, input logic expDone);
      checks++;
      if (actOut !== expOut || actDone !== expDone) begin
         errors++;
         $display("[TB] FAIL %s: got rst_out_n=%b seq_done=%b, expected rst_out_n=%b seq_done=%b",
                  nm, actOut, actDone, expOut, expDone);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic q, input int n);
      rstN = r;
      reqN = q;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Shared tail: after the assert edge the release is 16 edges later, then 4-edge gaps.
   task automatic addRecovery(input string tag);
      addVec(1, 1, 15, 3'b000, 0, {tag, "_hold"});
      addVec(1, 1, 1,  3'b001, 0, {tag, "_rel0"});
      addVec(1, 1, 3,  3'b001, 0, {tag, "_gap0"});
      addVec(1, 1, 1,  3'b011, 0, {tag, "_rel1"});
      addVec(1, 1, 3,  3'b011, 0, {tag, "_gap1"});
      addVec(1, 1, 1,  3'b111, 1, {tag, "_rel2"});
   endtask

   initial begin
      // Power-up: reset, then release at edges 18/22/26 after rst_n rises.
      addVec(0, 1, 3,  3'b000, 0, "reset");
      addVec(1, 1, 17, 3'b000, 0, "pu_hold");
      addVec(1, 1, 1,  3'b001, 0, "pu_rel0");
      addVec(1, 1, 3,  3'b001, 0, "pu_gap0");
      addVec(1, 1, 1,  3'b011, 0, "pu_rel1");
      addVec(1, 1, 3,  3'b011, 0, "pu_gap1");
      addVec(1, 1, 1,  3'b111, 1, "pu_rel2");
      addVec(1, 1, 10, 3'b111, 1, "pu_done");
`ifdef RST_SEQ_FILTER_EN
      addVec(1, 0, 7,  3'b111, 1, "short_low");
      addVec(1, 1, 3,  3'b111, 1, "short_ignored");
      addVec(1, 0, 8,  3'b111, 1, "long_low");
      addVec(1, 1, 1,  3'b111, 1, "long_wait");
      addVec(1, 1, 1,  3'b000, 0, "long_assert");
`else
      addVec(1, 0, 1,  3'b111, 1, "req_sample");
      addVec(1, 1, 1,  3'b111, 1, "req_sync");
      addVec(1, 1, 1,  3'b000, 0, "req_assert");
`endif
      addRecovery("redo");
      // Fresh reset, then a one-cycle glitch after hold has counted to 10.
      addVec(0, 1, 2,  3'b000, 0, "reset2");
      addVec(1, 1, 12, 3'b000, 0, "gl_hold");
      addVec(1, 0, 1,  3'b000, 0, "gl_low");
      addVec(1, 1, 1,  3'b000, 0, "gl_back");
      addVec(1, 1, 16, 3'b000, 0, "gl_restart");
      addVec(1, 1, 1,  3'b001, 0, "gl_rel0");
      addVec(1, 1, 4,  3'b011, 0, "gl_rel1");
`ifdef RST_SEQ_FILTER_EN
      addVec(1, 0, 8,  3'b111, 1, "mid_low");
      addVec(1, 1, 1,  3'b111, 1, "mid_wait");
      addVec(1, 1, 1,  3'b000, 0, "mid_assert");
`else
      // Request qualifies on exactly the edge where bit 2 would release.
      addVec(1, 1, 1,  3'b011, 0, "mid_pre");
      addVec(1, 0, 1,  3'b011, 0, "mid_low");
      addVec(1, 1, 1,  3'b011, 0, "mid_sync");
      addVec(1, 1, 1,  3'b000, 0, "req_wins");
`endif
      addRecovery("mid");

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rstN, vecs[i].reqN, vecs[i].edges);
         checkOutput(vecs[i].name, rstOutN, seqDone, vecs[i].expOut, vecs[i].expDone);
      end

      // Single domain, HOLD_CYCLES=1: release and done together 3 edges after reset.
      rstN2 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("one_reset", {2'b00, rstOutN2}, seqDone2, 3'b000, 0);
      rstN2 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("one_edge2", {2'b00, rstOutN2}, seqDone2, 3'b000, 0);
      @(posedge clk);
      #1;
      checkOutput("one_edge3", {2'b00, rstOutN2}, seqDone2, 3'b001, 1);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("one_hold", {2'b00, rstOutN2}, seqDone2, 3'b001, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
